// File: rtl/decode_stage_if.sv
// Handshake and bundle signals between fetch, the decode stage and its consumer.
// The slave modport is the decode stage's view; master is the fetch/consumer view.
// Optional trace outputs exist only when DECODE_TRACE_EN is defined.
interface decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5
);
    // Fetch side
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [PC_W-1:0]       in_pc;

    // Decoded bundle side
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_W-1:0]       out_pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm;
    logic                  imm_sel;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  illegal;

`ifdef DECODE_TRACE_EN
    logic [31:0]           trace_count;
    logic [31:0]           trace_last_illegal;
`endif

    modport slave (
`ifdef DECODE_TRACE_EN
        output trace_count,
        output trace_last_illegal,
`endif
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_instr,
        input  in_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output opcode,
        output funct3,
        output funct7,
        output rd,
        output rs1,
        output rs2,
        output imm,
        output imm_sel,
        output reg_write,
        output mem_read,
        output mem_write,
        output branch,
        output jump,
        output illegal
    );

    modport master (
`ifdef DECODE_TRACE_EN
        input  trace_count,
        input  trace_last_illegal,
`endif
        output flush,
        output in_valid,
        input  in_ready,
        output in_instr,
        output in_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  opcode,
        input  funct3,
        input  funct7,
        input  rd,
        input  rs1,
        input  rs2,
        input  imm,
        input  imm_sel,
        input  reg_write,
        input  mem_read,
        input  mem_write,
        input  branch,
        input  jump,
        input  illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage. One instruction+PC accepted per valid/ready
// handshake; opcode, fields, sign-extended immediate and control enables appear
// in the output register one cycle later. flush squashes the held bundle and
// refuses the current input. Optional feature macro: DECODE_TRACE_EN adds
// trace_count (output handshakes) and trace_last_illegal (last illegal word).
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I_ALU  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    logic [31:0]     instr;
    opcode_e         opc;
    logic            load;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;
    logic            imm_sel_d;
    logic            writes_rd;
    logic            mem_read_d;
    logic            mem_write_d;
    logic            branch_d;
    logic            jump_d;
    logic            illegal_d;

    assign instr = bus.in_instr;
    assign opc   = opcode_e'(instr[6:0]);

    // Ready whenever the output slot is empty or is being drained this cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // Format-selected immediate and control enables for the incoming word.
    always_comb begin
        imm32       = '0;
        imm_sel_d   = 1'b0;
        writes_rd   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        branch_d    = 1'b0;
        jump_d      = 1'b0;
        illegal_d   = 1'b0;
        unique case (opc)
            OP_R: begin
                writes_rd = 1'b1;
            end
            OP_I_ALU: begin
                imm32     = {{20{instr[31]}}, instr[31:20]};
                imm_sel_d = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                imm32      = {{20{instr[31]}}, instr[31:20]};
                imm_sel_d  = 1'b1;
                writes_rd  = 1'b1;
                mem_read_d = 1'b1;
            end
            OP_STORE: begin
                imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_sel_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BRANCH: begin
                imm32    = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
                branch_d = 1'b1;
            end
            OP_JAL: begin
                imm32     = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                writes_rd = 1'b1;
                jump_d    = 1'b1;
            end
            OP_JALR: begin
                imm32     = {{20{instr[31]}}, instr[31:20]};
                imm_sel_d = 1'b1;
                writes_rd = 1'b1;
                jump_d    = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm32     = {instr[31:12], 12'b0};
                imm_sel_d = 1'b1;
                writes_rd = 1'b1;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
        // Opcodes all end in 2'b11, but state the compressed-space rejection explicitly.
        if (instr[1:0] != 2'b11) begin
            imm32       = '0;
            imm_sel_d   = 1'b0;
            writes_rd   = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
            illegal_d   = 1'b1;
        end
        imm_d = XLEN'($signed(imm32));
    end

    // Output register: load on handshake, clear valid on flush or drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_pc    <= '0;
            bus.opcode    <= '0;
            bus.funct3    <= '0;
            bus.funct7    <= '0;
            bus.rd        <= '0;
            bus.rs1       <= '0;
            bus.rs2       <= '0;
            bus.imm       <= '0;
            bus.imm_sel   <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.branch    <= 1'b0;
            bus.jump      <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_pc    <= bus.in_pc;
            bus.opcode    <= instr[6:0];
            bus.funct3    <= instr[14:12];
            bus.funct7    <= instr[31:25];
            bus.rd        <= instr[11:7];
            bus.rs1       <= instr[19:15];
            bus.rs2       <= instr[24:20];
            bus.imm       <= imm_d;
            bus.imm_sel   <= imm_sel_d;
            bus.reg_write <= writes_rd && (instr[11:7] != 5'd0);
            bus.mem_read  <= mem_read_d;
            bus.mem_write <= mem_write_d;
            bus.branch    <= branch_d;
            bus.jump      <= jump_d;
            bus.illegal   <= illegal_d;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef DECODE_TRACE_EN
    // Trace counters: survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.trace_count        <= '0;
            bus.trace_last_illegal <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.trace_count <= bus.trace_count + 32'd1;
            if (load && illegal_d)
                bus.trace_last_illegal <= instr;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage with a behavioural reference model.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .REG_ADDR_W(RW)) bus ();

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .REG_ADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        imm_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b1;
    bundle_t     m_b     = '0;
    logic [31:0] m_tcount = '0;
    logic [31:0] m_tlast  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decode from the instruction-set rules using arithmetic on the word.
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t b;
        int s;
        logic [6:0] op;
        logic legal, wr;
        s  = $signed(w);
        op = w[6:0];
        b = '0;
        b.pc  = pc;
        b.op  = op;
        b.f3  = w[14:12];
        b.f7  = w[31:25];
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        legal = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        if (!legal) begin
            b.illegal = 1'b1;
            return b;
        end
        case (op)
            7'h13, 7'h03, 7'h67: b.imm = 32'(s >>> 20);
            7'h23: b.imm = 32'((s >>> 25) * 32) | 32'(w[11:7]);
            7'h63: b.imm = 32'((s >>> 31) * 4096) | (32'(w[7]) << 11)
                         | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            7'h37, 7'h17: b.imm = w & 32'hFFFF_F000;
            7'h6F: b.imm = 32'((s >>> 31) * 1048576) | (32'(w[19:12]) << 12)
                         | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: b.imm = 32'd0;
        endcase
        wr          = op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        b.reg_write = wr && (w[11:7] != 0);
        b.imm_sel   = op inside {7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h67};
        b.mem_read  = (op == 7'h03);
        b.mem_write = (op == 7'h23);
        b.branch    = (op == 7'h63);
        b.jump      = (op == 7'h6F) || (op == 7'h67);
        return b;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.pc = bus.out_pc; b.op = bus.opcode; b.f3 = bus.funct3; b.f7 = bus.funct7;
        b.rd = bus.rd; b.rs1 = bus.rs1; b.rs2 = bus.rs2; b.imm = bus.imm;
        b.imm_sel = bus.imm_sel; b.reg_write = bus.reg_write; b.mem_read = bus.mem_read;
        b.mem_write = bus.mem_write; b.branch = bus.branch; b.jump = bus.jump;
        b.illegal = bus.illegal;
        return b;
    endfunction

    // One clock: drive inputs, check at negedge, advance model past the posedge.
    task automatic cycle(input logic r, input logic iv, input logic [31:0] w,
                         input logic [31:0] pc, input logic ordy, input logic fl);
        bundle_t got;
        logic ld;
        rst = r;
        bus.in_valid = iv; bus.in_instr = w; bus.in_pc = pc;
        bus.out_ready = ordy; bus.flush = fl;
        @(negedge clk);
        check("out_valid", bus.out_valid, m_valid);
        check("in_ready", bus.in_ready, !m_valid || ordy);
        if (m_valid || m_zero) begin
            got = dut_bundle();
            check("bundle", 64'(got[$bits(bundle_t)-1:32]), 64'(m_b[$bits(bundle_t)-1:32]));
            check("bundle_lo", 64'(got[31:0]), 64'(m_b[31:0]));
        end
`ifdef DECODE_TRACE_EN
        check("trace_count", bus.trace_count, m_tcount);
        check("trace_last_illegal", bus.trace_last_illegal, m_tlast);
`endif
        ld = iv && (!m_valid || ordy) && !fl;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_zero = 1'b1; m_b = '0; m_tcount = '0; m_tlast = '0;
        end else begin
            if (m_valid && ordy) m_tcount = m_tcount + 1;
            if (fl) m_valid = 1'b0;
            else if (ld) begin
                m_valid = 1'b1;
                m_zero  = 1'b0;
                m_b     = ref_decode(w, pc);
                if (m_b.illegal) m_tlast = w;
            end else if (ordy) m_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) return {r[31:7], ops[k]};
        if (k == 9) return {r[31:7], ops[r[3:0] % 9][6:2], 2'b01};
        return r;
    endfunction

    initial begin
        logic [31:0] pc;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.in_pc = '0; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_imm", bus.imm, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_enables", {bus.reg_write, bus.imm_sel, bus.illegal}, 0);

        // addi x1,x0,5
        cycle(0, 1, 32'h0050_0093, 32'h100, 1, 0);
        check("addi_rd", bus.rd, 1);
        check("addi_imm", bus.imm, 5);
        check("addi_ctl", {bus.imm_sel, bus.reg_write, bus.out_valid}, 3'b111);
        // sw x2,-4(x1)
        cycle(0, 1, 32'hFE20_AE23, 32'h104, 1, 0);
        check("sw_imm", bus.imm, 32'hFFFF_FFFC);
        check("sw_ctl", {bus.mem_write, bus.reg_write, bus.rs1, bus.rs2}, {2'b10, 5'd1, 5'd2});
        // lui x5,0x12345 then addi x0,x0,1
        cycle(0, 1, 32'h1234_52B7, 32'h108, 1, 0);
        check("lui_imm", bus.imm, 32'h1234_5000);
        check("lui_wr", bus.reg_write, 1);
        cycle(0, 1, 32'h0010_0013, 32'h10C, 1, 0);
        check("addi_x0_wr", bus.reg_write, 0);

        // Backpressure for 3 cycles, then back-to-back release.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h0000_0513 + 32'(i << 20), 32'h200, 0, 0);
        check("hold_pc", bus.out_pc, 32'h10C);
        check("hold_imm", bus.imm, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, rand_instr(), 32'h300 + 32'(4 * i), 1, 0);

        // All-zero word is illegal; then flush the held bundle.
        cycle(0, 1, 32'h0000_0000, 32'h400, 1, 0);
        check("zero_illegal", bus.illegal, 1);
        check("zero_enables", {bus.reg_write, bus.mem_read, bus.mem_write,
                               bus.branch, bus.jump, bus.imm_sel}, 0);
        check("zero_imm", bus.imm, 0);
        cycle(0, 1, 32'h0050_0093, 32'h404, 0, 1);
        check("flush_valid", bus.out_valid, 0);

        // Reset mid-stream.
        cycle(0, 1, 32'h0050_0093, 32'h408, 0, 0);
        cycle(1, 1, 32'h0050_0093, 32'h40C, 0, 0);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_bundle", {bus.out_pc, bus.imm, bus.rd, bus.opcode, bus.reg_write}, 0);

        // Randomized traffic.
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_instr(), pc,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
            pc = pc + 4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
